// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the SPI master and the SPI slave.
//   spi_state_e : transfer state of the slave engine (IDLE, ACTIVE)
//   DATA_W_MIN / DATA_W_MAX : legal range for the word-length parameter
package spi_pkg;

  localparam int unsigned DATA_W_MIN = 2;
  localparam int unsigned DATA_W_MAX = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_slave_core_sync_edge.sv
// sync_edge: 2-FF synchroniser for an asynchronous pad, with optional
// rise/fall strobes built from one extra register.
//   pclk, presetn : system clock, synchronous active-low reset
//   pad           : asynchronous input
//   level         : synchronised level
//   rise, fall    : one-cycle strobes on synchronised transitions
//                   (tied low when EDGE_DET = 0)
// All flops reset to 0 so that a pad already low at reset (e.g. ss held
// mid-frame) produces no falling-edge strobe afterwards.
module sync_edge #(
  parameter bit EDGE_DET = 1'b1
) (
  input  logic pclk,
  input  logic presetn,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], pad};
    end
  end

  assign level = sync[1];

  if (EDGE_DET) begin : g_edge
    logic prev;

    always_ff @(posedge pclk) begin
      if (!presetn) begin
        prev <= 1'b0;
      end else begin
        prev <= sync[1];
      end
    end

    assign rise = sync[1] & ~prev;
    assign fall = ~sync[1] & prev;
  end else begin : g_no_edge
    assign rise = 1'b0;
    assign fall = 1'b0;
  end

endmodule

// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI responder engine, oversampling the SPI pads in pclk.
//   pclk, presetn          : system clock, synchronous active-low reset
//   cpol, cpha, lsb_first  : SPI mode and bit order (static during a frame)
//   sclk_pad_i, ss_pad_i, mosi_pad_i : asynchronous pads from the master
//   miso_pad_o, miso_oe    : serial data out and its output enable
//   tx_data/tx_valid/tx_ready : write port of the TX holding register
//   rx_data/rx_valid       : last received word and its update pulse
//   tx_underrun            : pulse when a word is loaded with no TX data
//   busy                   : frame in progress
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              sclk_pad_i,
  input  logic              ss_pad_i,
  input  logic              mosi_pad_i,
  output logic              miso_pad_o,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  spi_state_e state, state_next;

  logic sclk_level_unused, ss_level_unused;
  logic mosi_rise_unused, mosi_fall_unused;
  logic sclk_rise, sclk_fall;
  logic ss_rise, ss_fall;
  logic mosi_sync;

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift, rx_next;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] tx_hold;
  logic              hold_full;

  logic lead_edge, trail_edge;
  logic active_run, abort;
  logic sample_edge, shift_edge;
  logic word_done, load;

  sync_edge #(.EDGE_DET(1'b1)) u_sclk_sync (
    .pclk    (pclk),
    .presetn (presetn),
    .pad     (sclk_pad_i),
    .level   (sclk_level_unused),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  // ss is active-low: the pad's falling edge starts a frame.
  sync_edge #(.EDGE_DET(1'b1)) u_ss_sync (
    .pclk    (pclk),
    .presetn (presetn),
    .pad     (ss_pad_i),
    .level   (ss_level_unused),
    .rise    (ss_rise),
    .fall    (ss_fall)
  );

  sync_edge #(.EDGE_DET(1'b0)) u_mosi_sync (
    .pclk    (pclk),
    .presetn (presetn),
    .pad     (mosi_pad_i),
    .level   (mosi_sync),
    .rise    (mosi_rise_unused),
    .fall    (mosi_fall_unused)
  );

  // SCLK edge classification; an ss release wins over a same-cycle SCLK edge.
  assign lead_edge   = cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol ? sclk_rise : sclk_fall;
  assign abort       = (state == ACTIVE) & ss_rise;
  assign active_run  = (state == ACTIVE) & ~ss_rise;
  assign sample_edge = active_run & (cpha ? trail_edge : lead_edge);
  assign shift_edge  = active_run & (cpha ? lead_edge : trail_edge);
  assign word_done   = sample_edge & (bit_cnt == CNT_W'(DATA_W - 1));

  // A shift edge with bit_cnt at 0 is either the first shift edge of a word
  // (cpha=1) or the one following a word-completing sample (cpha=0), so a
  // single term covers both modes; cpha=0 also loads on ss assertion.
  assign load = (shift_edge & (bit_cnt == '0)) |
                ((state == IDLE) & ss_fall & ~cpha);

  assign rx_next = lsb_first ? {mosi_sync, rx_shift[DATA_W-1:1]}
                             : {rx_shift[DATA_W-2:0], mosi_sync};

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ss_fall) state_next = ACTIVE;
      ACTIVE:  if (ss_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_shift    <= '0;
      tx_hold     <= '0;
      hold_full   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      if (abort) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (sample_edge) begin
        rx_shift <= rx_next;
        if (word_done) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
          bit_cnt  <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (load) begin
        if (hold_full) begin
          tx_shift <= tx_hold;
        end else begin
          tx_shift    <= '1;
          tx_underrun <= 1'b1;
        end
      end else if (shift_edge) begin
        tx_shift <= lsb_first ? (tx_shift >> 1) : (tx_shift << 1);
      end

      // A write is only accepted while empty, so a same-cycle load has
      // already underrun and the write simply fills the register.
      if (tx_valid && !hold_full) begin
        tx_hold   <= tx_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign busy       = (state == ACTIVE);
  assign miso_oe    = busy;
  assign tx_ready   = ~hold_full;
  assign miso_pad_o = busy ? (lsb_first ? tx_shift[0] : tx_shift[DATA_W-1]) : 1'b1;

endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core (DATA_W = 8): a behavioural SPI
// master drives the pads; received words and MISO bits are compared with
// expectations from a table and from a word-level reference model.
module tb_spi_slave_core;

  localparam int H = 6;  // SCLK half period in pclk cycles

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic       sclk_pad = 1'b0, ss_pad = 1'b1, mosi_pad = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       miso_pad_o, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0] rx_data;

  always #5 pclk = ~pclk;

  spi_slave_core #(.DATA_W(8)) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .cpol        (cpol),
    .cpha        (cpha),
    .lsb_first   (lsb_first),
    .sclk_pad_i  (sclk_pad),
    .ss_pad_i    (ss_pad),
    .mosi_pad_i  (mosi_pad),
    .miso_pad_o  (miso_pad_o),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Observers
  logic [7:0] rx_q[$];
  int ur_cnt = 0;
  bit ur_window = 1'b0;
  int busy_cycles = 0;
  bit busy_watch = 1'b0;

  always @(negedge pclk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (tx_underrun && ur_window) ur_cnt++;
    if (busy_watch && busy) busy_cycles++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic write_tx(input logic [7:0] d);
    int n;
    n = 0;
    while (!tx_ready && n < 400) begin
      @(negedge pclk);
      n++;
    end
    check("tx_ready_wait", 32'(tx_ready), 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge pclk);
    tx_valid = 1'b0;
  endtask

  // Behavioural master. abort_bits > 0 stops the frame after that many bits.
  // The underrun window covers word start up to the last sample edge.
  task automatic spi_frame(input bit pol, input bit pha, input bit lsb, input int nwords,
                           input logic [7:0] mosi0, input logic [7:0] mosi1,
                           input int abort_bits,
                           output logic [7:0] miso0, output logic [7:0] miso1);
    logic [7:0] mw [2];
    logic [7:0] cap [2];
    int total, w, idx, nw, nidx;
    mw[0] = mosi0; mw[1] = mosi1;
    cap[0] = '0; cap[1] = '0;
    total = (abort_bits > 0) ? abort_bits : nwords * 8;
    @(negedge pclk);
    cpol = pol; cpha = pha; lsb_first = lsb; sclk_pad = pol;
    repeat (H) @(negedge pclk);
    ur_cnt = 0;
    ur_window = 1'b1;
    if (!pha) mosi_pad = mw[0][lsb ? 0 : 7];
    ss_pad = 1'b0;
    for (int b = 0; b < total; b++) begin
      w   = b / 8;
      idx = lsb ? (b % 8) : (7 - (b % 8));
      repeat (H) @(negedge pclk);
      if (b == 0) begin
        check("busy_in_frame", 32'(busy), 1);
        check("oe_in_frame", 32'(miso_oe), 1);
      end
      if (pha) begin
        sclk_pad = ~pol;
        mosi_pad = mw[w][idx];
        repeat (H) @(negedge pclk);
        cap[w][idx] = miso_pad_o;
        sclk_pad = pol;
      end else begin
        cap[w][idx] = miso_pad_o;
        sclk_pad = ~pol;
        repeat (H) @(negedge pclk);
        if (b == total - 1) ur_window = 1'b0;
        sclk_pad = pol;
        if (b + 1 < total) begin
          nw   = (b + 1) / 8;
          nidx = lsb ? ((b + 1) % 8) : (7 - ((b + 1) % 8));
          mosi_pad = mw[nw][nidx];
        end
      end
    end
    repeat (H) @(negedge pclk);
    ur_window = 1'b0;
    ss_pad = 1'b1;
    repeat (2 * H) @(negedge pclk);
    miso0 = cap[0];
    miso1 = cap[1];
  endtask

  task automatic run_single(input string name, input bit pol, input bit pha, input bit lsb,
                            input bit has_tx, input logic [7:0] tx, input logic [7:0] mosi,
                            input logic [7:0] exp_miso, input logic [7:0] exp_rx, input int exp_ur);
    logic [7:0] m0, m1;
    rx_q.delete();
    if (has_tx) write_tx(tx);
    spi_frame(pol, pha, lsb, 1, mosi, 8'h00, 0, m0, m1);
    check({name, "_rx_count"}, rx_q.size(), 1);
    if (rx_q.size() >= 1) check({name, "_rx_word"}, 32'(rx_q[0]), 32'(exp_rx));
    check({name, "_rx_held"}, 32'(rx_data), 32'(exp_rx));
    check({name, "_miso"}, 32'(m0), 32'(exp_miso));
    check({name, "_underrun"}, ur_cnt, exp_ur);
    check({name, "_idle_busy"}, 32'(busy), 0);
    check({name, "_idle_oe"}, 32'(miso_oe), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_miso"}, 32'(miso_pad_o), 1);
    check({name, "_oe"}, 32'(miso_oe), 0);
    check({name, "_tx_ready"}, 32'(tx_ready), 1);
    check({name, "_rx_data"}, 32'(rx_data), 0);
    check({name, "_rx_valid"}, 32'(rx_valid), 0);
    check({name, "_underrun"}, 32'(tx_underrun), 0);
    check({name, "_busy"}, 32'(busy), 0);
  endtask

  typedef struct {
    bit         pol, pha, lsb, has_tx;
    logic [7:0] tx, mosi, exp_miso, exp_rx;
    int         exp_ur;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [7:0] m0, m1;
    bit         rp, rh, rl, rt;
    logic [7:0] rtx, rmosi, emiso;

    tbl[0] = '{pol:1'b0, pha:1'b0, lsb:1'b0, has_tx:1'b1, tx:8'hA5, mosi:8'h3C, exp_miso:8'hA5, exp_rx:8'h3C, exp_ur:0};
    tbl[1] = '{pol:1'b1, pha:1'b1, lsb:1'b1, has_tx:1'b1, tx:8'h81, mosi:8'hF0, exp_miso:8'h81, exp_rx:8'hF0, exp_ur:0};
    tbl[2] = '{pol:1'b1, pha:1'b0, lsb:1'b0, has_tx:1'b0, tx:8'h00, mosi:8'h96, exp_miso:8'hFF, exp_rx:8'h96, exp_ur:1};
    tbl[3] = '{pol:1'b0, pha:1'b1, lsb:1'b0, has_tx:1'b1, tx:8'h5E, mosi:8'hC3, exp_miso:8'h5E, exp_rx:8'hC3, exp_ur:0};
    tbl[4] = '{pol:1'b1, pha:1'b1, lsb:1'b0, has_tx:1'b0, tx:8'h00, mosi:8'h0F, exp_miso:8'hFF, exp_rx:8'h0F, exp_ur:1};
    tbl[5] = '{pol:1'b0, pha:1'b0, lsb:1'b1, has_tx:1'b1, tx:8'h01, mosi:8'h80, exp_miso:8'h01, exp_rx:8'h80, exp_ur:0};

    presetn = 1'b0;
    repeat (3) @(negedge pclk);
    check_reset_outputs("por");
    presetn = 1'b1;
    repeat (4) @(negedge pclk);

    for (int i = 0; i < 6; i++) begin
      run_single($sformatf("vec%0d", i), tbl[i].pol, tbl[i].pha, tbl[i].lsb, tbl[i].has_tx,
                 tbl[i].tx, tbl[i].mosi, tbl[i].exp_miso, tbl[i].exp_rx, tbl[i].exp_ur);
    end

    // Mode 1, two words with ss held low; second TX word written once the
    // holding register frees up during the frame.
    rx_q.delete();
    write_tx(8'h11);
    check("b2b_hold_full", 32'(tx_ready), 0);
    fork
      spi_frame(1'b0, 1'b1, 1'b0, 2, 8'hA7, 8'h4B, 0, m0, m1);
      write_tx(8'h22);
    join
    check("b2b_rx_count", rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      check("b2b_rx0", 32'(rx_q[0]), 32'h A7);
      check("b2b_rx1", 32'(rx_q[1]), 32'h4B);
    end
    check("b2b_miso0", 32'(m0), 32'h11);
    check("b2b_miso1", 32'(m1), 32'h22);
    check("b2b_underrun", ur_cnt, 0);

    // Abort after 5 SCLK cycles, then a clean frame.
    rx_q.delete();
    write_tx(8'h3C);
    spi_frame(1'b0, 1'b0, 1'b0, 1, 8'hB5, 8'h00, 5, m0, m1);
    check("abort_rx_count", rx_q.size(), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_oe", 32'(miso_oe), 0);
    check("abort_miso_idle", 32'(miso_pad_o), 1);
    run_single("post_abort", 1'b0, 1'b0, 1'b0, 1'b1, 8'h69, 8'hD2, 8'h69, 8'hD2, 0);

    // One-cycle reset mid-word with TX held and ss still low.
    rx_q.delete();
    busy_cycles = 0;
    fork
      spi_frame(1'b0, 1'b0, 1'b0, 1, 8'hE7, 8'h00, 0, m0, m1);
      begin
        repeat (3 * H) @(negedge pclk);
        write_tx(8'h5A);
        check("rst_hold_full", 32'(tx_ready), 0);
        repeat (2 * H) @(negedge pclk);
        presetn = 1'b0;
        @(negedge pclk);
        check_reset_outputs("midrst");
        presetn = 1'b1;
        rx_q.delete();
        busy_watch = 1'b1;
      end
    join
    busy_watch = 1'b0;
    check("midrst_busy_cycles", busy_cycles, 0);
    check("midrst_rx_count", rx_q.size(), 0);
    run_single("post_rst", 1'b1, 1'b1, 1'b0, 1'b1, 8'hC6, 8'h2D, 8'hC6, 8'h2D, 0);

    // Randomised single-word frames against the word-level model:
    // MISO carries the offered word, or all-ones with one underrun.
    for (int i = 0; i < 16; i++) begin
      rp    = 1'($urandom_range(0, 1));
      rh    = 1'($urandom_range(0, 1));
      rl    = 1'($urandom_range(0, 1));
      rt    = 1'($urandom_range(0, 1));
      rtx   = 8'($urandom);
      rmosi = 8'($urandom);
      emiso = rt ? rtx : 8'hFF;
      run_single($sformatf("rnd%0d", i), rp, rh, rl, rt, rtx, rmosi, emiso, rmosi, rt ? 0 : 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
